// File: rtl/vxe_vpu_mthread_rf_pkg.sv
// vxe_vpu_mthread_rf_pkg: VPU_REG_IDX_* encoding, shared field widths and per-thread state type
package vxe_vpu_mthread_rf_pkg;
    localparam int ACC_W = 32;
    localparam int VL_W = 20;
    localparam int REG_W = 38;
    localparam logic [2:0] VPU_REG_IDX_ACC = 3'd0;
    localparam logic [2:0] VPU_REG_IDX_VL = 3'd1;
    localparam logic [2:0] VPU_REG_IDX_EN = 3'd2;
    localparam logic [2:0] VPU_REG_IDX_RS = 3'd3;
    localparam logic [2:0] VPU_REG_IDX_RT = 3'd4;
    localparam logic [2:0] VPU_REG_IDX_RD = 3'd5;
    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [VL_W-1:0] vl;
        logic en;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } thr_state_t;
endpackage

// File: rtl/vxe_vpu_mthread_rf_thread_slot.sv
// vxe_vpu_thread_slot: one thread's register set with write > acc > advance priority per register
module vxe_vpu_thread_slot
    import vxe_vpu_mthread_rf_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             wr_en,
    input  logic [2:0]       ridx,
    input  logic [REG_W-1:0] data,
    input  logic             adv_en,
    input  logic             acc_en,
    input  logic [ACC_W-1:0] acc_data,
    output thr_state_t       cur,
    output thr_state_t       nxt
);
    logic adv;
    assign adv = adv_en && cur.en && cur.vl != '0;
    always_comb begin
        nxt.acc = (wr_en && ridx == VPU_REG_IDX_ACC) ? data[ACC_W-1:0] : acc_en ? acc_data : cur.acc;
        nxt.vl = (wr_en && ridx == VPU_REG_IDX_VL) ? data[VL_W-1:0] : adv ? cur.vl - VL_W'(1) : cur.vl;
        nxt.en = (wr_en && ridx == VPU_REG_IDX_EN) ? data[0] : cur.en;
        nxt.rs = (wr_en && ridx == VPU_REG_IDX_RS) ? data : adv ? cur.rs + REG_W'(1) : cur.rs;
        nxt.rt = (wr_en && ridx == VPU_REG_IDX_RT) ? data : adv ? cur.rt + REG_W'(1) : cur.rt;
        nxt.rd = (wr_en && ridx == VPU_REG_IDX_RD) ? data : adv ? cur.rd + REG_W'(1) : cur.rd;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cur <= '0;
        else cur <= nxt;
    end
endmodule

// File: rtl/vxe_vpu_mthread_rf.sv
// vxe_vpu_mthread_rf: multi-thread VPU register file with registered per-thread read view.
// Define VXE_VPU_MTRF_BYPASS_EN to forward same-edge updates of rd_thr into out_*.
module vxe_vpu_mthread_rf
    import vxe_vpu_mthread_rf_pkg::*;
#(
    parameter int NTHR = 8,
    parameter int TW = $clog2(NTHR)
)(
    input  logic             clk,
    input  logic             nrst,
    input  logic [TW-1:0]    wr_thr,
    input  logic [2:0]       ridx,
    input  logic             wr_en,
    input  logic [REG_W-1:0] data,
    input  logic             adv_en,
    input  logic [TW-1:0]    adv_thr,
    input  logic             acc_en,
    input  logic [TW-1:0]    acc_thr,
    input  logic [ACC_W-1:0] acc_data,
    input  logic [TW-1:0]    rd_thr,
    output logic [ACC_W-1:0] out_acc,
    output logic [VL_W-1:0]  out_vl,
    output logic             out_en,
    output logic [REG_W-1:0] out_rs,
    output logic [REG_W-1:0] out_rt,
    output logic [REG_W-1:0] out_rd,
    output logic             out_vl_zero,
    output logic [NTHR-1:0]  out_en_mask,
    output logic             adv_err
);
`ifdef VXE_VPU_MTRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    thr_state_t cur [NTHR];
    thr_state_t nxt [NTHR];
    thr_state_t view;
    for (genvar t = 0; t < NTHR; t++) begin : g_slot
        vxe_vpu_thread_slot u_slot (
            .clk      (clk),
            .nrst     (nrst),
            .wr_en    (wr_en && wr_thr == TW'(t)),
            .ridx     (ridx),
            .data     (data),
            .adv_en   (adv_en && adv_thr == TW'(t)),
            .acc_en   (acc_en && acc_thr == TW'(t)),
            .acc_data (acc_data),
            .cur      (cur[t]),
            .nxt      (nxt[t])
        );
        assign out_en_mask[t] = cur[t].en;
    end
    assign view = BYP ? nxt[rd_thr] : cur[rd_thr];
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_acc <= '0;
            out_vl <= '0;
            out_en <= 1'b0;
            out_rs <= '0;
            out_rt <= '0;
            out_rd <= '0;
            out_vl_zero <= 1'b0;
            adv_err <= 1'b0;
        end else begin
            out_acc <= view.acc;
            out_vl <= view.vl;
            out_en <= view.en;
            out_rs <= view.rs;
            out_rt <= view.rt;
            out_rd <= view.rd;
            out_vl_zero <= view.vl == '0;
            // error judged on the pre-update state the advance saw
            adv_err <= adv_en && !(cur[adv_thr].en && cur[adv_thr].vl != '0);
        end
    end
endmodule
